// File: rtl/flp_mul_arb_pkg.sv
// flp_mul_arb_pkg: shared FP format constants and helpers.
// Holds the FWIDTH and BIAS derivations and single-precision defaults.
package flp_mul_arb_pkg;

   localparam int SP_EWIDTH = 8;
   localparam int SP_SWIDTH = 23;

   function automatic int fwidth(input int ew, input int sw);
      return 1 + ew + sw;
   endfunction

   function automatic int bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

endpackage

// File: rtl/flp_mul_arb_if.sv
// flp_mul_arb_if: request/result bundle of the shared multiplier.
// slave = arbiter side, master = requesters and result consumer.
interface flp_mul_arb_if
   import flp_mul_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int FWIDTH = fwidth(SP_EWIDTH, SP_SWIDTH),
   parameter int IDW    = $clog2(NREQ)
);

   logic [NREQ-1:0]        i_req_valid;
   logic [NREQ*FWIDTH-1:0] i_req_a;
   logic [NREQ*FWIDTH-1:0] i_req_b;
   logic [NREQ-1:0]        o_req_ready;
   logic                   o_res_valid;
   logic [FWIDTH-1:0]      o_res_p;
   logic [IDW-1:0]         o_res_id;
   logic                   i_res_ready;
   logic                   o_busy;

   modport slave (
      input  i_req_valid, i_req_a, i_req_b, i_res_ready,
      output o_req_ready, o_res_valid, o_res_p, o_res_id,
      output o_busy
   );

   modport master (
      output i_req_valid, i_req_a, i_req_b, i_res_ready,
      input  o_req_ready, o_res_valid, o_res_p, o_res_id,
      input  o_busy
   );

endinterface

// File: rtl/flp_mul.sv
// flp_mul: combinational IEEE-style multiply, round-to-nearest-even.
// Subnormal inputs and underflowing results flush to signed zero.
module flp_mul
   import flp_mul_arb_pkg::*;
#(
   parameter int EWIDTH = SP_EWIDTH,
   parameter int SWIDTH = SP_SWIDTH
) (
   input  logic [EWIDTH+SWIDTH:0] i_a,
   input  logic [EWIDTH+SWIDTH:0] i_b,
   output logic [EWIDTH+SWIDTH:0] o_p
);

   localparam int PW = 2 * (SWIDTH + 1);
   localparam int XW = EWIDTH + 2;
   localparam logic [XW-1:0] BIAS_X = XW'(bias(EWIDTH));
   localparam logic [XW-1:0] EMAX = XW'((1 << EWIDTH) - 1);

   logic              w_sa, w_sb, w_s;
   logic [EWIDTH-1:0] w_ea, w_eb;
   logic [SWIDTH-1:0] w_ma, w_mb;
   logic              w_za, w_zb, w_ia, w_ib, w_na, w_nb;
   logic [PW-1:0]     w_prod;
   logic              w_norm;
   logic [SWIDTH-1:0] w_frac;
   logic              w_g, w_st, w_rnd;
   logic [SWIDTH:0]   w_fr;
   logic [XW-1:0]     w_e;

   assign {w_sa, w_ea, w_ma} = i_a;
   assign {w_sb, w_eb, w_mb} = i_b;
   assign w_s  = w_sa ^ w_sb;
   assign w_za = (w_ea == '0);
   assign w_zb = (w_eb == '0);
   assign w_ia = (&w_ea) & (w_ma == '0);
   assign w_ib = (&w_eb) & (w_mb == '0);
   assign w_na = (&w_ea) & (w_ma != '0);
   assign w_nb = (&w_eb) & (w_mb != '0);

   assign w_prod = PW'({1'b1, w_ma}) * PW'({1'b1, w_mb});
   assign w_norm = w_prod[PW-1];

   // Normalise the product, round to nearest even, form the exponent.
   always_comb begin
      if (w_norm) begin
         w_frac = w_prod[PW-2 -: SWIDTH];
         w_g    = w_prod[SWIDTH];
         w_st   = |w_prod[SWIDTH-1:0];
      end else begin
         w_frac = w_prod[PW-3 -: SWIDTH];
         w_g    = w_prod[SWIDTH-1];
         w_st   = |w_prod[SWIDTH-2:0];
      end
      w_rnd = w_g & (w_st | w_frac[0]);
      w_fr  = {1'b0, w_frac} + {{SWIDTH{1'b0}}, w_rnd};
      w_e   = {2'b00, w_ea} + {2'b00, w_eb} - BIAS_X
            + {{(XW-1){1'b0}}, w_norm}
            + {{(XW-1){1'b0}}, w_fr[SWIDTH]};
   end

   // Specials take precedence, then range flushes, then the product.
   always_comb begin
      o_p = {w_s, w_e[EWIDTH-1:0], w_fr[SWIDTH-1:0]};
      if (w_na | w_nb | (w_ia & w_zb) | (w_za & w_ib)) begin
         o_p = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(SWIDTH-1){1'b0}}};
      end else if (w_ia | w_ib) begin
         o_p = {w_s, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
      end else if (w_za | w_zb) begin
         o_p = {w_s, {(EWIDTH+SWIDTH){1'b0}}};
      end else if (w_e[XW-1] || (w_e == '0)) begin
         o_p = {w_s, {(EWIDTH+SWIDTH){1'b0}}};
      end else if (w_e >= EMAX) begin
         o_p = {w_s, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
      end
   end

endmodule

// File: rtl/flp_rr_arb.sv
// flp_rr_arb: one-hot request arbiter for the shared multiplier.
// FLP_MUL_ARB_RR_EN selects round-robin, else fixed lowest-index priority.
module flp_rr_arb #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic [N-1:0] i_req,
   input  logic         i_en,
   input  logic         i_upd,
   output logic [N-1:0] o_gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

`ifdef FLP_MUL_ARB_RR_EN

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_nxt;

   function automatic logic [PW-1:0] wrap(input int v);
      return (v >= N) ? PW'(v - N) : PW'(v);
   endfunction

   // Grant the first requester at or after the pointer, wrapping at N.
   always_comb begin
      o_gnt = '0;
      w_nxt = r_ptr;
      if (i_en) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (i_req[wrap(int'(r_ptr) + k)]) begin
               o_gnt = '0;
               o_gnt[wrap(int'(r_ptr) + k)] = 1'b1;
               w_nxt = wrap(int'(r_ptr) + k + 1);
            end
         end
      end
   end

   // Move the pointer just past the index that was granted.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_ptr <= '0;
      end else if (i_upd) begin
         r_ptr <= w_nxt;
      end
   end

`else

   logic w_unused;
   assign w_unused = &{1'b0, clk, nrst, i_upd};

   // Lowest requesting index wins outright.
   always_comb begin
      o_gnt = '0;
      if (i_en) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) begin
               o_gnt = '0;
               o_gnt[k] = 1'b1;
            end
         end
      end
   end

`endif

endmodule

// File: rtl/flp_mul_arb.sv
// flp_mul_arb: arbiter + 2-stage pipeline around the shared multiplier.
// Define FLP_MUL_ARB_RR_EN for round-robin, else fixed priority.
module flp_mul_arb
   import flp_mul_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int EWIDTH = SP_EWIDTH,
   parameter int SWIDTH = SP_SWIDTH
) (
   input logic          clk,
   input logic          nrst,
   flp_mul_arb_if.slave bus
);

   localparam int FWIDTH = fwidth(EWIDTH, SWIDTH);
   localparam int IDW    = $clog2(NREQ);

   logic              w_adv1, w_adv2, w_en, w_hs;
   logic [NREQ-1:0]   w_gnt;
   logic [IDW-1:0]    w_id;
   logic [FWIDTH-1:0] w_a, w_b, w_p;

   logic              r_s1_valid;
   logic [FWIDTH-1:0] r_s1_a, r_s1_b;
   logic [IDW-1:0]    r_s1_id;
   logic              r_s2_valid;
   logic [FWIDTH-1:0] r_s2_p;
   logic [IDW-1:0]    r_s2_id;

   assign w_adv2 = ~r_s2_valid | bus.i_res_ready;
   assign w_adv1 = ~r_s1_valid | w_adv2;
   // Nothing is granted while reset is held.
   assign w_en   = w_adv1 & nrst;
   assign w_hs   = |(bus.i_req_valid & w_gnt);

   flp_rr_arb #(
      .N(NREQ)
   ) u_arb (
      .clk   (clk),
      .nrst  (nrst),
      .i_req (bus.i_req_valid),
      .i_en  (w_en),
      .i_upd (w_hs),
      .o_gnt (w_gnt)
   );

   // Steer the granted requester's operands and index toward S1.
   always_comb begin
      w_id = '0;
      w_a  = '0;
      w_b  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_gnt[k]) begin
            w_id = IDW'(k);
            w_a  = bus.i_req_a[k*FWIDTH +: FWIDTH];
            w_b  = bus.i_req_b[k*FWIDTH +: FWIDTH];
         end
      end
   end

   flp_mul #(
      .EWIDTH(EWIDTH),
      .SWIDTH(SWIDTH)
   ) u_mul (
      .i_a (r_s1_a),
      .i_b (r_s1_b),
      .o_p (w_p)
   );

   // S1: capture operands on a handshake, empty when advancing idle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_id    <= '0;
      end else if (w_adv1) begin
         r_s1_valid <= w_hs;
         if (w_hs) begin
            r_s1_a  <= w_a;
            r_s1_b  <= w_b;
            r_s1_id <= w_id;
         end
      end
   end

   // S2: register the product unless the consumer is stalling.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_s2_valid <= 1'b0;
         r_s2_p     <= '0;
         r_s2_id    <= '0;
      end else if (w_adv2) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_p  <= w_p;
            r_s2_id <= r_s1_id;
         end
      end
   end

   assign bus.o_req_ready = w_gnt;
   assign bus.o_res_valid = r_s2_valid;
   assign bus.o_res_p     = r_s2_p;
   assign bus.o_res_id    = r_s2_id;
   assign bus.o_busy      = r_s1_valid | r_s2_valid;

endmodule
